// File: rtl/uc_pkg.sv
// Shared definitions for the multicycle RISC-V control unit:
// FSM state encoding, the decoded opcode set, register-file write-source
// codes and trap cause codes.
package uc_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_EXEC_I,
    S_EXEC_LUI,
    S_EXEC_ADDR,
    S_MEM_RD,
    S_MEM_WR,
    S_EXEC_BR,
    S_EXEC_JAL,
    S_WRITE_BACK,
    S_TRAP
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  // Register-file write source
  localparam logic [1:0] RF_MEM = 2'b00;
  localparam logic [1:0] RF_ULA = 2'b01;
  localparam logic [1:0] RF_PC4 = 2'b10;
  localparam logic [1:0] RF_IMM = 2'b11;

  // Trap causes
  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

endpackage

// File: rtl/uc_wait_timer.sv
// Memory wait-cycle counter with timeout detection.
// Ports:
//   clk     - clock
//   clear   - synchronous clear (wins over count)
//   count   - a wait cycle is being spent this cycle
//   expired - this wait cycle is the TIMEOUT-th one
module uc_wait_timer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam int unsigned W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  // Counter holds the number of wait cycles already spent; the cycle
  // that would make it TIMEOUT is the last one allowed.
  assign expired = count && (cnt_q == W'(TIMEOUT - 1));

endmodule

// File: rtl/uc_asm_mc.sv
// Multicycle control unit for the RISC-V datapath (R/I ALU, LOAD, STORE,
// BRANCH, JAL, LUI) with a req/ready memory handshake, bounded memory
// wait, retired-instruction counter and trap on illegal opcode/timeout.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   opcode              - IR[6:0]
//   br_taken            - branch condition from the ULA
//   mem_ready           - memory completes the current access
//   mem_req             - memory access request
//   WE_RF, WE_MEM       - register file / data memory write enables
//   RF_din_sel          - register file write source
//   ULA_din2_sel        - second ULA operand select
//   addr_sel            - memory address source (1 = PC)
//   load_pc, load_ir    - PC / IR load enables
//   pc_next_sel         - PC source (always 0)
//   pc_adder_sel        - PC adder offset (1 = immediate)
//   instret             - retired-instruction count
//   trap, trap_cause    - trap status
module uc_asm_mc
  import uc_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             br_taken,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             WE_RF,
  output logic             WE_MEM,
  output logic [1:0]       RF_din_sel,
  output logic             ULA_din2_sel,
  output logic             addr_sel,
  output logic             load_pc,
  output logic             load_ir,
  output logic             pc_next_sel,
  output logic             pc_adder_sel,
  output logic [CNT_W-1:0] instret,
  output logic             trap,
  output logic [1:0]       trap_cause
);

  state_t           state_q, state_d;
  logic [1:0]       rf_sel_q, rf_sel_d;
  logic [1:0]       cause_q, cause_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             tmr_count, tmr_clear, expired, retire;

  // Counting only while waiting means any completed access or any
  // non-wait state clears the counter, so each entry starts from zero.
  always_comb begin
    tmr_count = (state_q inside {S_FETCH, S_MEM_RD, S_MEM_WR}) && !mem_ready;
    tmr_clear = reset || !tmr_count;
  end

  uc_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk     (clk),
    .clear   (tmr_clear),
    .count   (tmr_count),
    .expired (expired)
  );

  always_comb begin
    state_d  = state_q;
    rf_sel_d = rf_sel_q;
    cause_d  = cause_q;
    retire   = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ready) begin
          state_d = S_DECODE;
        end else if (expired) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_R:              state_d = S_EXEC_R;
          OP_I:              state_d = S_EXEC_I;
          OP_LOAD, OP_STORE: state_d = S_EXEC_ADDR;
          OP_BRANCH:         state_d = S_EXEC_BR;
          OP_JAL:            state_d = S_EXEC_JAL;
          OP_LUI:            state_d = S_EXEC_LUI;
          default: begin
            state_d = S_TRAP;
            cause_d = CAUSE_ILLEGAL;
          end
        endcase
      end
      S_EXEC_R, S_EXEC_I: begin
        rf_sel_d = RF_ULA;
        state_d  = S_WRITE_BACK;
      end
      S_EXEC_LUI: begin
        rf_sel_d = RF_IMM;
        state_d  = S_WRITE_BACK;
      end
      S_EXEC_ADDR: state_d = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: begin
        if (mem_ready) begin
          rf_sel_d = RF_MEM;
          state_d  = S_WRITE_BACK;
        end else if (expired) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_MEM_WR: begin
        if (mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end else if (expired) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_EXEC_BR, S_EXEC_JAL, S_WRITE_BACK: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase
    instret_d = retire ? instret_q + 1'b1 : instret_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      rf_sel_q  <= RF_MEM;
      cause_q   <= CAUSE_NONE;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      rf_sel_q  <= rf_sel_d;
      cause_q   <= cause_d;
      instret_q <= instret_d;
    end
  end

  // Outputs are forced low while reset is asserted so the reset cycle
  // itself reads all-zero, not only the IDLE cycle after it.
  always_comb begin
    mem_req      = 1'b0;
    WE_RF        = 1'b0;
    WE_MEM       = 1'b0;
    RF_din_sel   = RF_MEM;
    ULA_din2_sel = 1'b0;
    addr_sel     = 1'b0;
    load_pc      = 1'b0;
    load_ir      = 1'b0;
    pc_next_sel  = 1'b0;
    pc_adder_sel = 1'b0;
    trap         = 1'b0;
    trap_cause   = CAUSE_NONE;
    instret      = '0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          mem_req  = 1'b1;
          addr_sel = 1'b1;
          load_ir  = mem_ready;
        end
        S_EXEC_R:   RF_din_sel = RF_ULA;
        S_EXEC_I: begin
          RF_din_sel   = RF_ULA;
          ULA_din2_sel = 1'b1;
        end
        S_EXEC_LUI:  RF_din_sel = RF_IMM;
        S_EXEC_ADDR: ULA_din2_sel = 1'b1;
        S_MEM_RD: begin
          mem_req      = 1'b1;
          ULA_din2_sel = 1'b1;
        end
        S_MEM_WR: begin
          mem_req      = 1'b1;
          WE_MEM       = 1'b1;
          ULA_din2_sel = 1'b1;
          load_pc      = mem_ready;
        end
        S_EXEC_BR: begin
          load_pc      = 1'b1;
          pc_adder_sel = br_taken;
        end
        S_EXEC_JAL: begin
          WE_RF        = 1'b1;
          RF_din_sel   = RF_PC4;
          load_pc      = 1'b1;
          pc_adder_sel = 1'b1;
        end
        S_WRITE_BACK: begin
          WE_RF      = 1'b1;
          load_pc    = 1'b1;
          RF_din_sel = rf_sel_q;
        end
        S_TRAP:  trap = 1'b1;
        default: ;
      endcase
      trap_cause = cause_q;
      instret    = instret_q;
    end
  end

endmodule

// File: tb/tb_uc_asm_mc.sv
// Directed bench for uc_asm_mc (TIMEOUT = 4, CNT_W = 8).
// Output vector layout: {mem_req, WE_RF, WE_MEM, RF_din_sel[1:0],
// ULA_din2_sel, addr_sel, load_pc, load_ir, pc_next_sel, pc_adder_sel,
// trap, trap_cause[1:0]}.
module tb_uc_asm_mc;
  import uc_pkg::*;

  logic       clk;
  logic       reset;
  logic [6:0] opcode;
  logic       br_taken;
  logic       mem_ready;
  logic       mem_req, WE_RF, WE_MEM, ULA_din2_sel, addr_sel;
  logic       load_pc, load_ir, pc_next_sel, pc_adder_sel, trap;
  logic [1:0] RF_din_sel, trap_cause;
  logic [7:0] instret;
  logic [13:0] outs;

  int total = 0;
  int bad   = 0;

  //                                       m_r_w_ss_u_a_p_i_n_j_t_cc
  localparam logic [13:0] E_ZERO      = 14'b0_0_0_00_0_0_0_0_0_0_0_00;
  localparam logic [13:0] E_FETCH_RDY = 14'b1_0_0_00_0_1_0_1_0_0_0_00;
  localparam logic [13:0] E_FETCH_WT  = 14'b1_0_0_00_0_1_0_0_0_0_0_00;
  localparam logic [13:0] E_EXEC_R    = 14'b0_0_0_01_0_0_0_0_0_0_0_00;
  localparam logic [13:0] E_EXEC_I    = 14'b0_0_0_01_1_0_0_0_0_0_0_00;
  localparam logic [13:0] E_EXEC_LUI  = 14'b0_0_0_11_0_0_0_0_0_0_0_00;
  localparam logic [13:0] E_WB01      = 14'b0_1_0_01_0_0_1_0_0_0_0_00;
  localparam logic [13:0] E_WB11      = 14'b0_1_0_11_0_0_1_0_0_0_0_00;
  localparam logic [13:0] E_WB00      = 14'b0_1_0_00_0_0_1_0_0_0_0_00;
  localparam logic [13:0] E_ADDR      = 14'b0_0_0_00_1_0_0_0_0_0_0_00;
  localparam logic [13:0] E_MEMRD     = 14'b1_0_0_00_1_0_0_0_0_0_0_00;
  localparam logic [13:0] E_MEMWR_RDY = 14'b1_0_1_00_1_0_1_0_0_0_0_00;
  localparam logic [13:0] E_BR_T      = 14'b0_0_0_00_0_0_1_0_0_1_0_00;
  localparam logic [13:0] E_BR_N      = 14'b0_0_0_00_0_0_1_0_0_0_0_00;
  localparam logic [13:0] E_JAL       = 14'b0_1_0_10_0_0_1_0_0_1_0_00;
  localparam logic [13:0] E_TRAP01    = 14'b0_0_0_00_0_0_0_0_0_0_1_01;
  localparam logic [13:0] E_TRAP10    = 14'b0_0_0_00_0_0_0_0_0_0_1_10;

  uc_asm_mc #(.TIMEOUT(4), .CNT_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .opcode       (opcode),
    .br_taken     (br_taken),
    .mem_ready    (mem_ready),
    .mem_req      (mem_req),
    .WE_RF        (WE_RF),
    .WE_MEM       (WE_MEM),
    .RF_din_sel   (RF_din_sel),
    .ULA_din2_sel (ULA_din2_sel),
    .addr_sel     (addr_sel),
    .load_pc      (load_pc),
    .load_ir      (load_ir),
    .pc_next_sel  (pc_next_sel),
    .pc_adder_sel (pc_adder_sel),
    .instret      (instret),
    .trap         (trap),
    .trap_cause   (trap_cause)
  );

  assign outs = {mem_req, WE_RF, WE_MEM, RF_din_sel, ULA_din2_sel, addr_sel,
                 load_pc, load_ir, pc_next_sel, pc_adder_sel, trap, trap_cause};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Leaves the FSM in FETCH at posedge+1.
  task test_reset;
    reset = 1'b1; mem_ready = 1'b0; br_taken = 1'b0; opcode = OP_I;
    #1;
    total++;
    if (outs !== E_ZERO || instret !== 8'd0) begin
      bad++; $display("FAIL reset_cycle outs=%b instret=%0d expected outs=%b instret=0", outs, instret, E_ZERO);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    total++;
    if (outs !== E_ZERO || instret !== 8'd0) begin
      bad++; $display("FAIL idle_cycle outs=%b instret=%0d expected outs=%b instret=0", outs, instret, E_ZERO);
    end
    @(posedge clk); #1;
  endtask

  task test_back_to_back;
    logic [6:0]  ops  [12];
    logic [13:0] exps [12];
    logic [11:0] rdy;
    ops  = '{OP_I, OP_I, OP_I, OP_I, OP_R, OP_R, OP_R, OP_R,
             OP_LUI, OP_LUI, OP_LUI, OP_LUI};
    exps = '{E_FETCH_RDY, E_ZERO, E_EXEC_I, E_WB01,
             E_FETCH_RDY, E_ZERO, E_EXEC_R, E_WB01,
             E_FETCH_RDY, E_ZERO, E_EXEC_LUI, E_WB11};
    rdy  = 12'b1000_1000_1000;
    br_taken = 1'b0;
    for (int i = 0; i < 12; i++) begin
      opcode = ops[i]; mem_ready = rdy[11-i];
      #1;
      total++;
      if (outs !== exps[i]) begin
        bad++; $display("FAIL alu_b2b[%0d] outs=%b expected=%b", i, outs, exps[i]);
      end
      @(posedge clk); #1;
    end
    total++;
    if (instret !== 8'd3) begin
      bad++; $display("FAIL alu_b2b_instret got=%0d expected=3", instret);
    end
  endtask

  task test_load_wait;
    logic [13:0] exps [8];
    logic [7:0]  rdy;
    exps = '{E_FETCH_RDY, E_ZERO, E_ADDR, E_MEMRD, E_MEMRD, E_MEMRD, E_MEMRD, E_WB00};
    rdy  = 8'b1000_0010;
    opcode = OP_LOAD; br_taken = 1'b0;
    for (int i = 0; i < 8; i++) begin
      mem_ready = rdy[7-i];
      #1;
      total++;
      if (outs !== exps[i]) begin
        bad++; $display("FAIL load_wait[%0d] outs=%b expected=%b", i, outs, exps[i]);
      end
      @(posedge clk); #1;
    end
    total++;
    if (instret !== 8'd4) begin
      bad++; $display("FAIL load_instret got=%0d expected=4", instret);
    end
  endtask

  task test_store;
    logic [13:0] exps [4];
    logic [3:0]  rdy;
    exps = '{E_FETCH_RDY, E_ZERO, E_ADDR, E_MEMWR_RDY};
    rdy  = 4'b1001;
    opcode = OP_STORE; br_taken = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_ready = rdy[3-i];
      #1;
      total++;
      if (outs !== exps[i]) begin
        bad++; $display("FAIL store[%0d] outs=%b expected=%b", i, outs, exps[i]);
      end
      @(posedge clk); #1;
    end
    total++;
    if (instret !== 8'd5) begin
      bad++; $display("FAIL store_instret got=%0d expected=5", instret);
    end
  endtask

  task test_branch_jal;
    logic [6:0]  ops  [9];
    logic [13:0] exps [9];
    logic [8:0]  rdy, brt;
    ops  = '{OP_BRANCH, OP_BRANCH, OP_BRANCH, OP_BRANCH, OP_BRANCH, OP_BRANCH,
             OP_JAL, OP_JAL, OP_JAL};
    exps = '{E_FETCH_RDY, E_ZERO, E_BR_T, E_FETCH_RDY, E_ZERO, E_BR_N,
             E_FETCH_RDY, E_ZERO, E_JAL};
    rdy  = 9'b100_100_100;
    brt  = 9'b001_000_000;
    for (int i = 0; i < 9; i++) begin
      opcode = ops[i]; mem_ready = rdy[8-i]; br_taken = brt[8-i];
      #1;
      total++;
      if (outs !== exps[i]) begin
        bad++; $display("FAIL branch_jal[%0d] outs=%b expected=%b", i, outs, exps[i]);
      end
      @(posedge clk); #1;
    end
    total++;
    if (instret !== 8'd8) begin
      bad++; $display("FAIL branch_jal_instret got=%0d expected=8", instret);
    end
  endtask

  task test_illegal;
    logic [13:0] exps [5];
    exps = '{E_FETCH_RDY, E_ZERO, E_TRAP01, E_TRAP01, E_TRAP01};
    opcode = 7'b1111111; mem_ready = 1'b1; br_taken = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++;
      if (outs !== exps[i]) begin
        bad++; $display("FAIL illegal[%0d] outs=%b expected=%b", i, outs, exps[i]);
      end
      @(posedge clk); #1;
    end
    total++;
    if (instret !== 8'd8) begin
      bad++; $display("FAIL illegal_instret got=%0d expected=8", instret);
    end
  endtask

  task test_timeout;
    logic [13:0] exps [6];
    exps = '{E_FETCH_WT, E_FETCH_WT, E_FETCH_WT, E_FETCH_WT, E_TRAP10, E_TRAP10};
    opcode = OP_I; mem_ready = 1'b0; br_taken = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      total++;
      if (outs !== exps[i]) begin
        bad++; $display("FAIL timeout[%0d] outs=%b expected=%b", i, outs, exps[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task test_timeout_rescue;
    logic [13:0] exps [7];
    logic [6:0]  rdy;
    exps = '{E_FETCH_WT, E_FETCH_WT, E_FETCH_WT, E_FETCH_RDY, E_ZERO, E_EXEC_I, E_WB01};
    rdy  = 7'b0001_000;
    opcode = OP_I; br_taken = 1'b0;
    for (int i = 0; i < 7; i++) begin
      mem_ready = rdy[6-i];
      #1;
      total++;
      if (outs !== exps[i]) begin
        bad++; $display("FAIL timeout_rescue[%0d] outs=%b expected=%b", i, outs, exps[i]);
      end
      @(posedge clk); #1;
    end
    total++;
    if (instret !== 8'd1) begin
      bad++; $display("FAIL rescue_instret got=%0d expected=1", instret);
    end
  endtask

  initial begin
    test_reset;
    test_back_to_back;
    test_load_wait;
    test_store;
    test_branch_jal;
    test_illegal;
    test_reset;
    test_timeout;
    test_reset;
    test_timeout_rescue;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
